irq_ctrl: RTL

//   Interrupt controller for the single-cycle CPU. Latches external interrupt edges, applies a mask
//   and priority, and presents one request plus target vector to the control unit. The control unit

---
 rtl/irq_ctrl_if.sv | 29 ++
 rtl/irq_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// CPU <-> interrupt controller signal bundle; master = control unit / stimulus, slave = irq_ctrl.
interface irq_ctrl_if #(
    parameter int unsigned NIRQ  = 4,
    parameter int unsigned VEC_W = 10
);
    localparam int unsigned IDW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    logic [NIRQ-1:0]  irq_in;
    logic             mask_we;
    logic [NIRQ-1:0]  mask_din;
    logic             int_en;
    logic             ack;
    logic             reti;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic [IDW-1:0]   irq_id;
    logic [NIRQ-1:0]  pending;
    logic [NIRQ-1:0]  in_service;

    modport master (
        output irq_in, mask_we, mask_din, int_en, ack, reti,
        input  irq_req, irq_vec, irq_id, pending, in_service
    );

    modport slave (
        input  irq_in, mask_we, mask_din, int_en, ack, reti,
        output irq_req, irq_vec, irq_id, pending, in_service
    );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-latching, masked, fixed-priority interrupt controller (source 0 highest).
// Define IRQ_NEST_EN to allow higher-priority sources to preempt one in service.
module irq_ctrl #(
    parameter int unsigned      NIRQ     = 4,
    parameter int unsigned      VEC_W    = 10,
    parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
    input logic       clk,
    input logic       reset,
    irq_ctrl_if.slave bus
);
    localparam int unsigned IDW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e           state_q, state_d;
    logic [NIRQ-1:0]  pending_q, pending_d;
    logic [NIRQ-1:0]  mask_q, mask_d;
    logic [NIRQ-1:0]  in_service_q, in_service_d;
    logic [NIRQ-1:0]  irq_hist_q;
    logic [IDW-1:0]   id_q, id_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic [NIRQ-1:0]  rise;
    logic [NIRQ-1:0]  eligible;
    logic [NIRQ-1:0]  pending_clr;
    logic             has_cand;
    logic [IDW-1:0]   cand_idx;
    logic             can_raise;

    assign rise     = bus.irq_in & ~irq_hist_q;
    assign eligible = pending_q & ~mask_q & {NIRQ{bus.int_en}};

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        has_cand = 1'b0;
        cand_idx = '0;
        for (int unsigned i = NIRQ; i > 0; i--) begin
            if (eligible[i-1]) begin
                has_cand = 1'b1;
                cand_idx = IDW'(i - 1);
            end
        end
    end

`ifdef IRQ_NEST_EN
    logic [IDW-1:0]  isr_idx;
    logic [NIRQ-1:0] isr_rest;

    always_comb begin
        isr_idx = '0;
        for (int unsigned i = NIRQ; i > 0; i--) begin
            if (in_service_q[i-1]) isr_idx = IDW'(i - 1);
        end
    end

    assign isr_rest  = in_service_q & ~(NIRQ'(1) << isr_idx);
    assign can_raise = has_cand && ((in_service_q == '0) || (cand_idx < isr_idx));
`else
    assign can_raise = has_cand && (in_service_q == '0);
`endif

    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        id_d         = id_q;
        vec_d        = vec_q;
        pending_clr  = '0;
        mask_d       = bus.mask_we ? bus.mask_din : mask_q;

        case (state_q)
            IDLE: begin
                if (can_raise) begin
                    state_d = REQ;
                    id_d    = cand_idx;
                    vec_d   = VEC_BASE + (VEC_W'(cand_idx) << 2);
                end
            end
            REQ: begin
                if (bus.ack) begin
                    state_d                = SERVICE;
                    pending_clr[id_q]      = 1'b1;
                    in_service_d[id_q]     = 1'b1;
                end else if (!bus.int_en || mask_q[id_q]) begin
`ifdef IRQ_NEST_EN
                    // A withdrawn preemption falls back to the interrupted handler.
                    state_d = (in_service_q != '0) ? SERVICE : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            SERVICE: begin
`ifdef IRQ_NEST_EN
                if (bus.reti) begin
                    in_service_d[isr_idx] = 1'b0;
                    state_d               = (isr_rest != '0) ? SERVICE : IDLE;
                end else if (can_raise) begin
                    state_d = REQ;
                    id_d    = cand_idx;
                    vec_d   = VEC_BASE + (VEC_W'(cand_idx) << 2);
                end
`else
                if (bus.reti) begin
                    in_service_d[id_q] = 1'b0;
                    state_d            = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the source being acked wins over the clear.
        pending_d = (pending_q & ~pending_clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= '1;
            in_service_q <= '0;
            irq_hist_q   <= '0;
            id_q         <= '0;
            vec_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            irq_hist_q   <= bus.irq_in;
            id_q         <= id_d;
            vec_q        <= vec_d;
        end
    end

    assign bus.irq_req    = (state_q == REQ);
    assign bus.irq_vec    = vec_q;
    assign bus.irq_id     = id_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule
